ce_sequencer: RTL and testbench

// Sequences one CE convolution engine over a full output feature map. Walks output channel, row and

---
 rtl/ce_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ce_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ce_sequencer.sv
// Drives one CE engine over a full output feature map. It hands out windows under credit control,
// then shifts and optionally ReLUs each result and streams it out through a small FWFT FIFO.
module ce_sequencer #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int KERNEL     = 7,
    parameter int OUT_CH     = 8,
    parameter int LAT        = 3,
    parameter int D_W        = 23,
    parameter int SR         = 2,
    parameter int RELU       = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int OW    = IMG_W - KERNEL + 1,
    localparam int OH    = IMG_H - KERNEL + 1,
    localparam int COL_W = (OW > 1) ? $clog2(OW) : 1,
    localparam int ROW_W = (OH > 1) ? $clog2(OH) : 1,
    localparam int SEL_W = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             win_valid,
    output logic             win_ready,
    output logic [ROW_W-1:0] win_row,
    output logic [COL_W-1:0] win_col,
    output logic [SEL_W-1:0] w_sel,
    output logic             ce_en_in,
    input  logic             ce_en_out,
    input  logic [D_W-1:0]   ce_d_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [D_W-1:0]   res_data,
    output logic             res_last,
    output logic             err
);

    localparam int N     = OUT_CH * OH * OW;
    localparam int CNT_W = $clog2(N + 1);
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int SUM_W = OCC_W + 1;

    if (LAT < 1 || FIFO_DEPTH < 2 || IMG_W < KERNEL || IMG_H < KERNEL) begin : g_param_check
        $error("ce_sequencer: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [COL_W-1:0]   col_cnt;
    logic [ROW_W-1:0]   row_cnt;
    logic [SEL_W-1:0]   sel_cnt;
    logic [OCC_W-1:0]   inflight, occ;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   res_cnt;
    logic [D_W-1:0]     fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic               issue, last_issue, pop, push, fifo_full, credit, in_frame, err_set, retire;

    function automatic logic [D_W-1:0] post_proc(input logic [D_W-1:0] d);
        logic signed [D_W-1:0] t;
        t = $signed(d) >>> SR;
        if (RELU != 0 && t < 0)
            t = '0;
        return t;
    endfunction

    assign issue      = win_valid & win_ready;
    assign ce_en_in   = issue;
    assign last_issue = issue && col_cnt == COL_W'(OW - 1) && row_cnt == ROW_W'(OH - 1)
                        && sel_cnt == SEL_W'(OUT_CH - 1);
    assign res_valid  = (occ != '0);
    assign res_data   = fifo_data[rd_ptr];
    assign res_last   = res_valid & fifo_last[rd_ptr];
    assign pop        = res_valid & res_ready;
    assign fifo_full  = (occ == OCC_W'(FIFO_DEPTH));
    // Issued-but-unreturned results already own a FIFO slot, so the FIFO can never overflow.
    assign credit     = (SUM_W'(inflight) + SUM_W'(occ)) < SUM_W'(FIFO_DEPTH);
    assign in_frame   = (state != S_IDLE);
    assign push       = ce_en_out & in_frame & (~fifo_full | pop);
    assign err_set    = ce_en_out & (~in_frame | (fifo_full & ~pop));
    assign retire     = ce_en_out & (inflight != '0);
    assign win_row    = row_cnt;
    assign win_col    = col_cnt;
    assign w_sel      = sel_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_issue) state_nxt = S_DRAIN;
            S_DRAIN: if (pop && res_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        win_ready = (state == S_RUN) & credit;
    end

    // Scan order: column innermost, then row, then weight bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
            sel_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            col_cnt <= '0;
            row_cnt <= '0;
            sel_cnt <= '0;
        end else if (issue) begin
            if (col_cnt == COL_W'(OW - 1)) begin
                col_cnt <= '0;
                if (row_cnt == ROW_W'(OH - 1)) begin
                    row_cnt <= '0;
                    sel_cnt <= (sel_cnt == SEL_W'(OUT_CH - 1)) ? '0 : sel_cnt + SEL_W'(1);
                end else begin
                    row_cnt <= row_cnt + ROW_W'(1);
                end
            end else begin
                col_cnt <= col_cnt + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
            occ      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            res_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            case ({issue, retire})
                2'b10:   inflight <= inflight + OCC_W'(1);
                2'b01:   inflight <= inflight - OCC_W'(1);
                default: inflight <= inflight;
            endcase
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (state == S_IDLE && start)
                res_cnt <= '0;
            else if (push)
                res_cnt <= res_cnt + CNT_W'(1);
            if (err_set)
                err <= 1'b1;
        end
    end

    // FIFO storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= post_proc(ce_d_out);
            fifo_last[wr_ptr] <= (res_cnt == CNT_W'(N - 1));
        end
    end

endmodule

// File: tb/tb_ce_sequencer.sv
// Randomized bench for ce_sequencer: a 9x9/K7/2-channel frame checked against a transaction-level
// model of the scan order, credit rule, result post-processing and frame handshake.
module tb_ce_sequencer;

    localparam int IMG = 9, K = 7, OC = 2, LAT = 2, DW = 23, SR = 2, DEPTH = 4;
    localparam int OW = IMG - K + 1, OH = IMG - K + 1, N = OC * OH * OW;
    localparam int CW = 2, RW = 2, SW = 1;

    logic          clk, rst, start, win_valid, res_ready, ce_en_out;
    logic [DW-1:0] ce_d_out;
    logic          busy, done, win_ready, ce_en_in, res_valid, res_last, err;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic [SW-1:0] w_sel;
    logic [DW-1:0] res_data;
    logic          busy_b, done_b, win_ready_b, ce_en_in_b, res_valid_b, res_last_b, err_b;
    logic [RW-1:0] win_row_b;
    logic [CW-1:0] win_col_b;
    logic [SW-1:0] w_sel_b;
    logic [DW-1:0] res_data_b;

    ce_sequencer #(.IMG_W(IMG), .IMG_H(IMG), .KERNEL(K), .OUT_CH(OC), .LAT(LAT), .D_W(DW),
                   .SR(SR), .RELU(1), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
        .w_sel(w_sel), .ce_en_in(ce_en_in), .ce_en_out(ce_en_out), .ce_d_out(ce_d_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .err(err));

    ce_sequencer #(.IMG_W(IMG), .IMG_H(IMG), .KERNEL(K), .OUT_CH(OC), .LAT(LAT), .D_W(DW),
                   .SR(SR), .RELU(0), .FIFO_DEPTH(DEPTH)) u_dut_nr (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
        .win_valid(win_valid), .win_ready(win_ready_b), .win_row(win_row_b), .win_col(win_col_b),
        .w_sel(w_sel_b), .ce_en_in(ce_en_in_b), .ce_en_out(ce_en_out), .ce_d_out(ce_d_out),
        .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b),
        .res_last(res_last_b), .err(err_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {int vr; int vn; bit last;} ent_t;
    ent_t q[$];

    int n_checks = 0, n_errs = 0;
    int cyc = 0, issued, pushed, inflight_m, iss_cnt, start_cyc, end_cyc, last_d, n_gen = 0;
    int wv_mode, rr_mode;
    bit idle_m, done_pend, err_m, frame_end, last_iss, start_req, inject_req;
    bit pe [LAT];
    int pd [LAT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Shift right by SR as floor division, then optional ReLU, reduced to DW bits.
    function automatic int post(input int d, input bit relu);
        int div, r;
        div = 1 << SR;
        r = d / div;
        if (d < 0 && r * div != d) r = r - 1;
        if (relu && r < 0) r = 0;
        return r & ((1 << DW) - 1);
    endfunction

    function automatic int exp_idx(input int k);
        return (((k / (OH * OW)) << RW) + ((k / OW) % OH)) * (1 << CW) + (k % OW);
    endfunction

    function automatic int gen_data();
        n_gen++;
        if (n_gen % 5 == 1) return -8;
        return int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
    endfunction

    task automatic model_reset();
        q.delete();
        issued = 0; pushed = 0; inflight_m = 0; iss_cnt = 0;
        idle_m = 1; done_pend = 0; err_m = 0; last_iss = 0;
        for (int i = 0; i < LAT; i++) begin pe[i] = 0; pd[i] = 0; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0; start = 0; win_valid = 0; res_ready = 0; ce_en_out = 0; ce_d_out = '0;
        start_req = 0; inject_req = 0;
        model_reset();
        #1;
        chk("rst_ctrl", {busy, done, win_ready, ce_en_in, res_valid, res_last, err}, 0);
        chk("rst_idx", {w_sel, win_row, win_col}, 0);
        chk("rst_ctrl_nr", {busy_b, done_b, win_ready_b, res_valid_b, res_last_b, err_b}, 0);
        @(negedge clk);
        #2 rst = 1;
    endtask

    task automatic step();
        bit strobe, pop_m, run_m, credit, iss_m, exp_done, exp_last, accept, full_m, was_idle;
        int d_in;
        ent_t e;
        @(negedge clk);
        for (int i = LAT - 1; i > 0; i--) begin pe[i] = pe[i-1]; pd[i] = pd[i-1]; end
        pe[0] = last_iss; pd[0] = last_d;
        ce_en_out = pe[LAT-1] | inject_req;
        ce_d_out  = DW'(pd[LAT-1]);
        inject_req = 0;
        start = start_req; start_req = 0;
        case (wv_mode)
            0: win_valid = 1;
            1: win_valid = (cyc % 2 == 0);
            2: win_valid = ($urandom_range(0, 3) != 0);
            default: win_valid = 0;
        endcase
        case (rr_mode)
            0: res_ready = 1;
            2: res_ready = ($urandom_range(0, 2) != 0);
            default: res_ready = 0;
        endcase
        #1;
        strobe   = ce_en_out;
        d_in     = pd[LAT-1];
        exp_done = done_pend;
        was_idle = idle_m;
        run_m    = !idle_m && !exp_done && issued < N;
        credit   = (inflight_m + q.size()) < DEPTH;
        iss_m    = run_m && credit && win_valid;
        pop_m    = (q.size() > 0) && res_ready;
        full_m   = (q.size() == DEPTH);
        exp_last = (q.size() > 0) ? q[0].last : 1'b0;

        chk("win_ready", win_ready, run_m && credit);
        chk("ce_en_in", ce_en_in, iss_m);
        chk("busy", busy, !idle_m);
        chk("done", done, exp_done);
        chk("res_valid", res_valid, q.size() > 0);
        chk("res_last", res_last, exp_last);
        chk("err", err, err_m);
        chk("ctrl_nr", {win_ready_b, ce_en_in_b, busy_b, done_b, res_valid_b, res_last_b, err_b},
            {run_m && credit, iss_m, !idle_m, exp_done, q.size() > 0, exp_last, err_m});
        if (run_m) begin
            chk("index", {w_sel, win_row, win_col}, exp_idx(issued));
            chk("index_nr", {w_sel_b, win_row_b, win_col_b}, exp_idx(issued));
        end
        if (pop_m) begin
            e = q.pop_front();
            chk("data_relu", res_data, e.vr);
            chk("data_raw", res_data_b, e.vn);
            if (e.last) done_pend = 1;
        end
        if (strobe) begin
            if (was_idle || (full_m && !pop_m)) begin
                err_m = 1;
            end else begin
                pushed++;
                e.vr = post(d_in, 1); e.vn = post(d_in, 0); e.last = (pushed == N);
                q.push_back(e);
            end
            if (inflight_m > 0) inflight_m--;
        end
        if (iss_m) begin inflight_m++; issued++; end
        if (ce_en_in) iss_cnt++;
        accept = start && was_idle;
        if (exp_done) begin idle_m = 1; done_pend = 0; frame_end = 1; end_cyc = cyc; end
        if (accept) begin
            idle_m = 0; issued = 0; pushed = 0; iss_cnt = 0; start_cyc = cyc;
        end
        last_iss = ce_en_in;
        last_d   = gen_data();
        cyc++;
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_done(input int bound);
        int n;
        n = 0;
        frame_end = 0;
        while (!frame_end && n < bound) begin step(); n++; end
        chk("frame_end", frame_end, 1);
    endtask

    initial begin
        rst = 0; start = 0; win_valid = 0; res_ready = 0; ce_en_out = 0; ce_d_out = '0;
        wv_mode = 0; rr_mode = 0;
        do_reset();

        // full-rate frame: scan order, last tag and minimum frame time
        wv_mode = 0; rr_mode = 0; start_req = 1;
        run_to_done(200);
        chk("frame_time", end_cyc - start_cyc, N + LAT + 2);

        wv_mode = 1; rr_mode = 2; start_req = 1;
        run_to_done(400);

        // downstream stalled: only DEPTH issues, then resume
        wv_mode = 0; rr_mode = 3; start_req = 1;
        run_steps(20);
        chk("credit_issues", iss_cnt, DEPTH);
        chk("credit_stall", win_ready, 0);
        rr_mode = 0;
        run_to_done(200);
        chk("err_after_stall", err, 0);

        for (int f = 0; f < 3; f++) begin
            wv_mode = 2; rr_mode = 2; start_req = 1;
            run_to_done(600);
        end

        // reset with two results in flight, then a clean restart
        wv_mode = 0; rr_mode = 0; start_req = 1;
        run_steps(3);
        chk("inflight_before_rst", iss_cnt, 2);
        do_reset();
        start_req = 1;
        run_to_done(200);
        chk("err_after_restart", err, 0);

        // overflow strobe sets a sticky err; a start while busy is ignored
        wv_mode = 0; rr_mode = 3; start_req = 1;
        run_steps(20);
        inject_req = 1;
        run_steps(2);
        chk("err_set", err, 1);
        start_req = 1;
        run_steps(3);
        rr_mode = 0;
        run_to_done(300);
        chk("err_sticky", err, 1);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
